// File: rtl/uart_rx_if.sv
// Serial-line and received-byte signals of the UART receiver.
// The slave modport is the receiver side; master is the side that drives the line and consumes bytes.
interface uart_rx_if;
    logic [15:0] UART_CPB;
    logic        rx_serial;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_frame_err;
    logic        rx_busy;

    modport master (
        output UART_CPB,
        output rx_serial,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_busy
    );

    modport slave (
        input  UART_CPB,
        input  rx_serial,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a configurable synchronizer and mid-bit sampling.
// Frame errors arm a break guard, so a line held low is not re-read as a new start bit.
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    // state   | meaning
    // S_IDLE  | waiting for rx_s low (and for line high after a break)
    // S_START | counting to the middle of the start bit, glitch check
    // S_DATA  | sampling 8 data bits at bit centres, LSB first
    // S_STOP  | sampling the stop bit, emitting valid or frame error
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 state;
    logic [15:0]            cntr;
    logic [2:0]             bit_cntr;
    logic [7:0]             shreg;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   brk_wait;
    logic [7:0]             rx_data_q;
    logic                   valid_q;
    logic                   err_q;
    logic                   busy_q;
    logic [15:0]            half_cpb;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign half_cpb = bus.UART_CPB >> 1;

    assign bus.rx_data      = rx_data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_frame_err = err_q;
    assign bus.rx_busy      = busy_q;

    // Terminal counts use >= so a mid-frame change of UART_CPB cannot strand the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cntr      <= 16'd0;
            bit_cntr  <= 3'd0;
            shreg     <= 8'h00;
            sync_q    <= {SYNC_STAGES{1'b1}};
            brk_wait  <= 1'b0;
            rx_data_q <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.rx_serial};
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    cntr <= 16'd0;
                    if (brk_wait) begin
                        if (rx_s) brk_wait <= 1'b0;
                    end else if (!rx_s) begin
                        state  <= S_START;
                        busy_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (cntr >= half_cpb) begin
                        cntr <= 16'd0;
                        if (rx_s) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            bit_cntr <= 3'd0;
                            state    <= S_DATA;
                        end
                    end else begin
                        cntr <= cntr + 16'd1;
                    end
                end
                S_DATA: begin
                    if (cntr >= bus.UART_CPB) begin
                        shreg[bit_cntr] <= rx_s;
                        cntr            <= 16'd0;
                        bit_cntr        <= bit_cntr + 3'd1;
                        if (bit_cntr == 3'd7) state <= S_STOP;
                    end else begin
                        cntr <= cntr + 16'd1;
                    end
                end
                S_STOP: begin
                    if (cntr >= bus.UART_CPB) begin
                        cntr   <= 16'd0;
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        if (rx_s) begin
                            rx_data_q <= shreg;
                            valid_q   <= 1'b1;
                        end else begin
                            err_q    <= 1'b1;
                            brk_wait <= 1'b1;
                        end
                    end else begin
                        cntr <= cntr + 16'd1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
